// File: rtl/trait_profile_scorer.sv
// Purpose: accumulates per-trait answer scores over a window of WINDOW answers, then thresholds them into a trait vector.
// Latency: profile_valid rises the cycle after the final accepted answer of a window.
// Backpressure: answer_ready is held low while a profile waits. The profile is held until profile_ready or clear.
//
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   clear                       - synchronous abort of the current window or pending profile
//   answer_valid/ready, answers - answer vector input handshake
//   profile_valid/ready         - profile output handshake
//   traits, scores              - thresholded traits and packed per-trait scores, valid with profile_valid
//   sample_count                - answers accepted in the current window
module trait_profile_scorer #(
    parameter int                    NUM_TRAITS  = 11,
    parameter int                    WINDOW      = 8,
    parameter int                    CNT_W       = 4,
    parameter int                    THRESHOLD   = 5,
    parameter logic [NUM_TRAITS-1:0] INVERT_MASK = '1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        answer_valid,
    output logic                        answer_ready,
    input  logic [NUM_TRAITS-1:0]       answers,
    output logic                        profile_valid,
    input  logic                        profile_ready,
    output logic [NUM_TRAITS-1:0]       traits,
    output logic [NUM_TRAITS*CNT_W-1:0] scores,
    output logic [7:0]                  sample_count
);

    typedef enum logic {COLLECT, REPORT} state_e;

    localparam logic [7:0]       LAST_IDX = 8'(WINDOW - 1);
    localparam logic [CNT_W:0]   THR      = (CNT_W+1)'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e                      state_q, state_d;
    logic [NUM_TRAITS*CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [NUM_TRAITS-1:0]       traits_q, traits_d, thr_hit, eff;
    logic [7:0]                  sample_q, sample_d;
    // Holds answer_ready low until the first clock edge after reset release.
    logic                        rdy_en_q;
    logic                        accept;

    assign eff           = answers ^ INVERT_MASK;
    assign profile_valid = (state_q == REPORT);
    assign answer_ready  = rdy_en_q && (state_q == COLLECT);
    assign accept        = answer_valid && answer_ready;
    assign scores        = profile_valid ? cnt_q : '0;
    assign traits        = profile_valid ? traits_q : '0;
    assign sample_count  = sample_q;

    // Candidate counts if the current answer were accepted, and their threshold result.
    always_comb begin
        cnt_inc = cnt_q;
        thr_hit = '0;
        for (int i = 0; i < NUM_TRAITS; i++) begin
            if (eff[i] && (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                cnt_inc[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_ONE;
            end
            thr_hit[i] = ({1'b0, cnt_inc[i*CNT_W +: CNT_W]} >= THR);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        traits_d = traits_q;
        sample_d = sample_q;
        if (clear) begin
            // Wins over any simultaneous accept or profile handshake.
            state_d  = COLLECT;
            cnt_d    = '0;
            traits_d = '0;
            sample_d = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        cnt_d    = cnt_inc;
                        sample_d = sample_q + 8'd1;
                        if (sample_q == LAST_IDX) begin
                            state_d  = REPORT;
                            traits_d = thr_hit;
                        end
                    end
                end
                REPORT: begin
                    if (profile_ready) begin
                        state_d  = COLLECT;
                        cnt_d    = '0;
                        traits_d = '0;
                        sample_d = '0;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            traits_q <= '0;
            sample_q <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            traits_q <= traits_d;
            sample_q <= sample_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trait_profile_scorer.sv
// Purpose: self-checking bench for trait_profile_scorer with a reference model and expected-profile queue.
// Latency: one model step per clock; outputs are sampled on the falling edge.
// Backpressure: profile_ready is driven low for stretches to hold a profile.
module tb_trait_profile_scorer;

    localparam int NT  = 11;
    localparam int CW  = 4;
    localparam int WIN = 8;
    localparam int THR = 5;
    localparam logic [NT-1:0] MASK = '1;

    typedef struct {
        logic [NT-1:0]    traits;
        logic [NT*CW-1:0] scores;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              clear = 1'b0;
    logic              answer_valid = 1'b0;
    logic              answer_ready;
    logic [NT-1:0]     answers = '0;
    logic              profile_valid;
    logic              profile_ready = 1'b0;
    logic [NT-1:0]     traits;
    logic [NT*CW-1:0]  scores;
    logic [7:0]        sample_count;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   m_cnt[NT];
    int   m_samples;
    bit   m_report;

    trait_profile_scorer #(
        .NUM_TRAITS(NT), .WINDOW(WIN), .CNT_W(CW), .THRESHOLD(THR), .INVERT_MASK(MASK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .answer_valid(answer_valid), .answer_ready(answer_ready), .answers(answers),
        .profile_valid(profile_valid), .profile_ready(profile_ready),
        .traits(traits), .scores(scores), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_zero();
        for (int i = 0; i < NT; i++) m_cnt[i] = 0;
        m_samples = 0;
        m_report  = 1'b0;
    endfunction

    function automatic exp_t model_profile();
        exp_t e;
        for (int i = 0; i < NT; i++) begin
            e.scores[i*CW +: CW] = CW'(m_cnt[i]);
            e.traits[i]          = (m_cnt[i] >= THR);
        end
        return e;
    endfunction

    // Drives one cycle starting just after a rising edge; checks and advances the model at the falling edge.
    task automatic cycle(input logic vld, input logic [NT-1:0] ans, input logic prdy, input logic clr);
        logic [NT-1:0] e;
        answer_valid  = vld;
        answers       = ans;
        profile_ready = prdy;
        clear         = clr;
        @(negedge clk);
        chk("profile_valid", profile_valid, m_report);
        chk("answer_ready", answer_ready, !m_report);
        chk("sample_count", sample_count, m_samples);
        if (m_report) begin
            chk("profile_queued", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                chk("traits", traits, exp_q[0].traits);
                chk("scores", scores, exp_q[0].scores);
            end
        end else begin
            chk("traits_idle", traits, 0);
            chk("scores_idle", scores, 0);
        end
        if (clr) begin
            if (m_report && exp_q.size() > 0) void'(exp_q.pop_front());
            model_zero();
        end else if (m_report) begin
            if (prdy) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                model_zero();
            end
        end else if (vld) begin
            e = ans ^ MASK;
            for (int i = 0; i < NT; i++)
                if (e[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
            m_samples++;
            if (m_samples == WIN) begin
                m_report = 1'b1;
                exp_q.push_back(model_profile());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        answer_valid  = 1'b0;
        clear         = 1'b0;
        profile_ready = 1'b0;
        rst_n         = 1'b0;
        #2;
        chk("rst_profile_valid", profile_valid, 0);
        chk("rst_answer_ready", answer_ready, 0);
        chk("rst_traits", traits, 0);
        chk("rst_scores", scores, 0);
        chk("rst_sample_count", sample_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rel_answer_ready_low", answer_ready, 0);
        @(posedge clk);
        #1;
        chk("rel_answer_ready_high", answer_ready, 1);
        chk("rel_sample_count", sample_count, 0);
        model_zero();
        exp_q.delete();
    endtask

    initial begin
        model_zero();
        #1;
        do_reset();

        // Reset mid-window after three accepts.
        for (int i = 0; i < 3; i++) cycle(1'b1, NT'($urandom), 1'b0, 1'b0);
        chk("pre_reset_count", sample_count, 3);
        do_reset();

        // All-agree window.
        for (int i = 0; i < WIN; i++) cycle(1'b1, 11'h000, 1'b0, 1'b0);
        chk("agree_valid", profile_valid, 1);
        chk("agree_scores", scores, 44'h88888888888);
        chk("agree_traits", traits, 11'h7FF);
        chk("agree_count", sample_count, 8);
        cycle(1'b0, 11'h000, 1'b1, 1'b0);

        // Mixed window followed by backpressure.
        for (int i = 0; i < 5; i++) cycle(1'b1, 11'h001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 11'h7FF, 1'b0, 1'b0);
        chk("mixed_scores", scores, 44'h55555555550);
        chk("mixed_traits", traits, 11'h7FE);
        for (int i = 0; i < 3; i++) cycle(1'b1, 11'h000, 1'b0, 1'b0);
        chk("bp_scores", scores, 44'h55555555550);
        chk("bp_count", sample_count, 8);
        cycle(1'b0, 11'h000, 1'b1, 1'b0);
        chk("hs_valid", profile_valid, 0);
        chk("hs_ready", answer_ready, 1);
        chk("hs_scores", scores, 0);

        // Gapped input.
        for (int i = 0; i < 16; i++) cycle((i % 2) == 0, 11'h000, 1'b0, 1'b0);
        chk("gap_valid", profile_valid, 1);
        chk("gap_scores", scores, 44'h88888888888);
        cycle(1'b0, 11'h000, 1'b1, 1'b0);

        // Clear with a simultaneous accept, then clear in REPORT.
        for (int i = 0; i < 6; i++) cycle(1'b1, 11'h000, 1'b0, 1'b0);
        cycle(1'b1, 11'h000, 1'b0, 1'b1);
        chk("clr_count", sample_count, 0);
        chk("clr_scores", scores, 0);
        for (int i = 0; i < WIN; i++) cycle(1'b1, 11'h0F0, 1'b0, 1'b0);
        chk("clr_rep_valid_before", profile_valid, 1);
        cycle(1'b0, 11'h000, 1'b0, 1'b1);
        chk("clr_rep_valid", profile_valid, 0);
        chk("clr_rep_ready", answer_ready, 1);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 3) != 0, NT'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 40) == 0);
        for (int i = 0; i < 4 && m_report; i++) cycle(1'b0, 11'h000, 1'b1, 1'b0);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
